// File: rtl/mem_port_client_if.sv
// ============================================================================
// Module      : mem_port_client_if
// Description : Bus bundle between the CPU core, mem_port_client and the RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_client_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_valid;
    logic [DW-1:0] if_data;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic          d_valid;
    logic [DW-1:0] d_rdata;

    logic [AW-1:0] ram_addr1;
    logic [AW-1:0] ram_addr2;
    logic [AW-1:0] ram_addw;
    logic [DW-1:0] ram_wdata;
    logic          ram_wren;
    logic [DW-1:0] ram_data1;
    logic [DW-1:0] ram_data2;

    // master: the port client itself; slave: core requesters plus RAM
    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_data1, ram_data2,
        output if_valid, if_data, d_ready, d_valid, d_rdata,
        output ram_addr1, ram_addr2, ram_addw, ram_wdata, ram_wren
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_data1, ram_data2,
        input  if_valid, if_data, d_ready, d_valid, d_rdata,
        input  ram_addr1, ram_addr2, ram_addw, ram_wdata, ram_wren
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_client.sv
// ============================================================================
// Module      : mem_port_client
// Description : RAM initiator for fetch and load/store with a posted write
//               buffer and store-to-load forwarding on both read paths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_client #(
    parameter int AW         = 12,
    parameter int DW         = 16,
    parameter int WBUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_client_if.master   bus
);

    localparam int               c_PW    = $clog2(WBUF_DEPTH);
    localparam int               c_CW    = c_PW + 1;
    localparam logic [c_CW-1:0]  c_DEPTH = c_CW'(WBUF_DEPTH);

    logic [AW-1:0]   r_wb_addr [WBUF_DEPTH];
    logic [DW-1:0]   r_wb_data [WBUF_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic            r_if_valid;
    logic            r_if_hit;
    logic [DW-1:0]   r_if_fwd;
    logic            r_d_valid;
    logic            r_d_hit;
    logic [DW-1:0]   r_d_fwd;

    logic            w_ready;
    logic            w_push;
    logic            w_pop;
    logic            w_d_rd;
    logic [c_PW-1:0] w_idx;
    logic            w_if_hit;
    logic [DW-1:0]   w_if_fwd;
    logic            w_d_hit;
    logic [DW-1:0]   w_d_fwd;

    assign w_ready = ~bus.d_we | (r_count < c_DEPTH);
    assign w_push  = bus.d_req & bus.d_we & w_ready;
    assign w_pop   = (r_count != '0);
    assign w_d_rd  = bus.d_req & ~bus.d_we;

    assign bus.d_ready   = w_ready;
    assign bus.ram_addr1 = bus.if_addr;
    assign bus.ram_addr2 = bus.d_addr;
    assign bus.ram_wren  = w_pop;
    assign bus.ram_addw  = w_pop ? r_wb_addr[r_rd_ptr] : '0;
    assign bus.ram_wdata = w_pop ? r_wb_data[r_rd_ptr] : '0;

    assign bus.if_valid  = r_if_valid;
    assign bus.if_data   = r_if_hit ? r_if_fwd : (r_if_valid ? bus.ram_data1 : '0);
    assign bus.d_valid   = r_d_valid;
    assign bus.d_rdata   = r_d_hit ? r_d_fwd : (r_d_valid ? bus.ram_data2 : '0);

    // Walk entries oldest to youngest so the last match wins; the draining
    // head is still included because the RAM returns pre-write data.
    always_comb begin
        w_idx    = r_rd_ptr;
        w_if_hit = 1'b0;
        w_if_fwd = '0;
        w_d_hit  = 1'b0;
        w_d_fwd  = '0;
        for (int k = 0; k < WBUF_DEPTH; k++) begin
            w_idx = r_rd_ptr + c_PW'(k);
            if (c_CW'(k) < r_count) begin
                if (r_wb_addr[w_idx] == bus.if_addr) begin
                    w_if_hit = 1'b1;
                    w_if_fwd = r_wb_data[w_idx];
                end
                if (r_wb_addr[w_idx] == bus.d_addr) begin
                    w_d_hit = 1'b1;
                    w_d_fwd = r_wb_data[w_idx];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_if_valid <= 1'b0;
            r_if_hit   <= 1'b0;
            r_if_fwd   <= '0;
            r_d_valid  <= 1'b0;
            r_d_hit    <= 1'b0;
            r_d_fwd    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            r_count    <= r_count + c_CW'(w_push) - c_CW'(w_pop);
            r_if_valid <= bus.if_req;
            r_if_hit   <= bus.if_req & w_if_hit;
            r_if_fwd   <= w_if_fwd;
            r_d_valid  <= w_d_rd;
            r_d_hit    <= w_d_rd & w_d_hit;
            r_d_fwd    <= w_d_fwd;
        end
    end

    // Entry storage needs no reset: only slots covered by r_count are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_wb_addr[r_wr_ptr] <= bus.d_addr;
            r_wb_data[r_wr_ptr] <= bus.d_wdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_client.sv
// ============================================================================
// Module      : tb_mem_port_client
// Description : Self-checking bench for mem_port_client with a RAM model and
//               a software-view reference memory plus pending-write queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_client;

    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk;
    logic rst_n;

    mem_port_client_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_client #(.AW(AW), .DW(DW), .WBUF_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: registered reads, read-before-write, plus a bench preload port
    logic [DW-1:0] mem [4096];
    logic          pl_we;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clk) begin
        bus.ram_data1 <= mem[bus.ram_addr1];
        bus.ram_data2 <= mem[bus.ram_addr2];
        if (bus.ram_wren) mem[bus.ram_addw] <= bus.ram_wdata;
        else if (pl_we)   mem[pl_addr]      <= pl_data;
    end

    // Reference: what software should see, what the RAM should hold, and
    // the writes accepted but not yet drained.
    logic [DW-1:0] sw_mem    [4096];
    logic [DW-1:0] ram_model [4096];
    wr_t           wq [$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic ireq, input logic [AW-1:0] iaddr,
                         input logic dreq, input logic dwe,
                         input logic [AW-1:0] daddr, input logic [DW-1:0] dwd,
                         output logic acc);
        logic          exp_ready;
        logic [DW-1:0] e_if;
        logic [DW-1:0] e_d;
        @(negedge clk);
        bus.if_req  = ireq;
        bus.if_addr = iaddr;
        bus.d_req   = dreq;
        bus.d_we    = dwe;
        bus.d_addr  = daddr;
        bus.d_wdata = dwd;
        #1;
        exp_ready = !dwe || (wq.size() < DEPTH);
        chk("d_ready", bus.d_ready, exp_ready);
        if (wq.size() > 0) begin
            chk("ram_wren", bus.ram_wren, 1);
            chk("ram_addw", bus.ram_addw, wq[0].a);
            chk("ram_wdata", bus.ram_wdata, wq[0].d);
        end else begin
            chk("ram_wren_idle", bus.ram_wren, 0);
            chk("ram_addw_idle", bus.ram_addw, 0);
            chk("ram_wdata_idle", bus.ram_wdata, 0);
        end
        e_if = sw_mem[iaddr];
        e_d  = sw_mem[daddr];
        acc  = dreq && dwe && exp_ready;
        @(posedge clk);
        if (wq.size() > 0) begin
            ram_model[wq[0].a] = wq[0].d;
            void'(wq.pop_front());
        end
        if (acc) begin
            wq.push_back('{daddr, dwd});
            sw_mem[daddr] = dwd;
        end
        #1;
        chk("if_valid", bus.if_valid, ireq);
        if (ireq) chk("if_data", bus.if_data, e_if);
        chk("d_valid", bus.d_valid, dreq && !dwe);
        if (dreq && !dwe) chk("d_rdata", bus.d_rdata, e_d);
    endtask

    task automatic reset_outputs_chk(input string tag);
        chk({tag, "_ram_wren"}, bus.ram_wren, 0);
        chk({tag, "_ram_addw"}, bus.ram_addw, 0);
        chk({tag, "_ram_wdata"}, bus.ram_wdata, 0);
        chk({tag, "_if_valid"}, bus.if_valid, 0);
        chk({tag, "_d_valid"}, bus.d_valid, 0);
        chk({tag, "_if_data"}, bus.if_data, 0);
        chk({tag, "_d_rdata"}, bus.d_rdata, 0);
    endtask

    logic          acc;
    logic          hold;
    logic          r_ireq, r_dreq, r_dwe;
    logic [AW-1:0] r_iaddr, r_daddr;
    logic [DW-1:0] r_wd;

    initial begin
        rst_n       = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        pl_we       = 1'b0;
        pl_addr     = '0;
        pl_data     = '0;

        // Preload RAM while the DUT is held in reset
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            pl_we   = 1'b1;
            pl_addr = AW'(i);
            pl_data = (i == 'h010) ? 16'h1234 : DW'($urandom);
            sw_mem[i]    = pl_data;
            ram_model[i] = pl_data;
        end
        @(negedge clk);
        pl_we = 1'b0;
        #1;
        reset_outputs_chk("rst");
        chk("rst_d_ready", bus.d_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain read, then valid must drop
        cycle(1, 12'h010, 0, 0, 12'h000, 16'h0000, acc);
        chk("plain_read_value", bus.if_data, 16'h1234);
        cycle(0, 12'h000, 0, 0, 12'h000, 16'h0000, acc);

        // Write then read through the draining head, then fetch from RAM
        cycle(0, 12'h000, 1, 1, 12'h0A5, 16'hBEEF, acc);
        cycle(0, 12'h000, 1, 0, 12'h0A5, 16'h0000, acc);
        chk("fwd_head_value", bus.d_rdata, 16'hBEEF);
        cycle(0, 12'h000, 0, 0, 12'h000, 16'h0000, acc);
        cycle(1, 12'h0A5, 0, 0, 12'h000, 16'h0000, acc);
        chk("fetch_after_drain", bus.if_data, 16'hBEEF);

        // Youngest of two writes to the same address
        cycle(0, 12'h000, 1, 1, 12'h020, 16'h1111, acc);
        cycle(0, 12'h000, 1, 1, 12'h020, 16'h2222, acc);
        cycle(0, 12'h000, 1, 0, 12'h020, 16'h0000, acc);
        chk("youngest_value", bus.d_rdata, 16'h2222);

        // Three back-to-back writes; RAM order checked per cycle
        cycle(0, 12'h000, 1, 1, 12'h030, 16'hA001, acc);
        cycle(0, 12'h000, 1, 1, 12'h031, 16'hA002, acc);
        cycle(0, 12'h000, 1, 1, 12'h032, 16'hA003, acc);
        cycle(0, 12'h000, 0, 0, 12'h000, 16'h0000, acc);

        // Concurrent fetch and data read, plus fetch racing a same-edge write
        cycle(1, 12'h100, 1, 0, 12'h200, 16'h0000, acc);
        cycle(1, 12'h040, 1, 1, 12'h040, 16'h7777, acc);
        cycle(1, 12'h040, 0, 0, 12'h000, 16'h0000, acc);
        chk("fetch_fwd_value", bus.if_data, 16'h7777);

        // Reset while a write is pending and a fetch response is in flight
        cycle(0, 12'h000, 1, 1, 12'h050, 16'hC0DE, acc);
        cycle(1, 12'h010, 1, 1, 12'h051, 16'hD00D, acc);
        @(negedge clk);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        bus.d_we   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        reset_outputs_chk("midrst");
        wq.delete();
        for (int i = 0; i < 4096; i++) sw_mem[i] = ram_model[i];
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 12'h000, 0, 0, 12'h000, 16'h0000, acc);
        cycle(1, 12'h051, 1, 0, 12'h050, 16'h0000, acc);

        // Randomized traffic on a small address window to provoke hits
        hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                r_ireq  = 1'($urandom);
                r_iaddr = 12'h020 + 12'($urandom_range(0, 7));
                r_dreq  = 1'($urandom);
                r_dwe   = 1'($urandom);
                r_daddr = 12'h020 + 12'($urandom_range(0, 7));
                r_wd    = DW'($urandom);
            end
            cycle(r_ireq, r_iaddr, r_dreq, r_dwe, r_daddr, r_wd, acc);
            hold = r_dreq && r_dwe && !acc;
        end

        // Let the buffer drain, then compare RAM contents with the model
        cycle(0, 12'h000, 0, 0, 12'h000, 16'h0000, acc);
        cycle(0, 12'h000, 0, 0, 12'h000, 16'h0000, acc);
        cycle(0, 12'h000, 0, 0, 12'h000, 16'h0000, acc);
        for (int a = 'h020; a < 'h058; a++) begin
            chk("ram_contents", mem[a], ram_model[a]);
        end
        chk("ram_0a5", mem[12'h0A5], 16'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
